// File: rtl/uart_bridge_pkg.sv
// Shared opcodes, frame constants and state encodings for the UART host bridge.
package uart_bridge_pkg;

  localparam logic [7:0] CMD_READ   = 8'h52;
  localparam logic [7:0] CMD_WRITE  = 8'h57;
  localparam logic [7:0] RSP_WACK   = 8'h4B;
  localparam int         TX_FRAME_W = 10;

  typedef enum logic [2:0] {
    P_IDLE,
    P_ADDR_HI,
    P_ADDR_LO,
    P_DATA,
    P_BUS,
    P_REPLY
  } parser_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// Serial byte receiver: 2-FF synchronizer, mid-bit sampling, start/stop framing checks.
module uart_byte_rx
  import uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 9236
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err_pulse
);

  localparam int             CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             line_prev;
  rx_state_t        state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  // Synchronizer stage; line_prev provides the falling-edge reference.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0   <= 1'b1;
      sync_p1   <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync_p0   <= serial_in;
      sync_p1   <= sync_p0;
      line_prev <= sync_p1;
    end
  end

  // Bit timing and framing stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= RX_IDLE;
      clk_cnt         <= '0;
      bit_idx         <= '0;
      shift           <= '0;
      rx_byte         <= '0;
      rx_valid        <= 1'b0;
      frame_err_pulse <= 1'b0;
    end else begin
      rx_valid        <= 1'b0;
      frame_err_pulse <= 1'b0;
      case (state)
        RX_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (line_prev && !sync_p1) state <= RX_START;
        end
        RX_START: begin
          if (clk_cnt == HALF_BIT) begin
            clk_cnt <= '0;
            if (sync_p1) begin
              frame_err_pulse <= 1'b1;
              state           <= RX_IDLE;
            end else begin
              state <= RX_DATA;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == FULL_BIT) begin
            clk_cnt <= '0;
            shift   <= {sync_p1, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt == FULL_BIT) begin
            clk_cnt <= '0;
            state   <= RX_IDLE;
            if (sync_p1) begin
              rx_valid <= 1'b1;
              rx_byte  <= shift;
            end else begin
              frame_err_pulse <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_host_bridge.sv
// Host serial command parser driving a req/ack memory bus, with serial read-data replies.
// Define UART_BRIDGE_WRITE_ACK_EN to answer each completed write with 'K'.
module uart_host_bridge
  import uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 9236,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_UART_TX,
  output logic        o_UART_RX,
  output logic [15:0] o_bus_addr,
  output logic [7:0]  o_bus_wdata,
  input  logic [7:0]  i_bus_rdata,
  output logic        o_bus_req,
  output logic        o_bus_rw,
  input  logic        i_bus_ack,
  output logic        o_busy,
  output logic        o_frame_err,
  output logic        o_overrun
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

  logic [7:0]              rx_byte;
  logic                    rx_valid;
  logic                    frame_err_pulse;
  parser_state_t           state;
  logic [TIMEOUT_BITS-1:0] to_cnt;
  logic                    in_cmd;
  logic [7:0]              reply_byte;
  logic                    tx_load;
  logic                    tx_busy;
  logic [TX_FRAME_W-1:0]   tx_shift;
  logic [CNT_W-1:0]        tx_cnt;
  logic [3:0]              tx_bits;

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk            (clk),
    .reset          (reset),
    .serial_in      (i_UART_TX),
    .rx_byte        (rx_byte),
    .rx_valid       (rx_valid),
    .frame_err_pulse(frame_err_pulse)
  );

  assign in_cmd = (state == P_ADDR_HI) || (state == P_ADDR_LO) || (state == P_DATA);
  assign o_busy = (state != P_IDLE);

  // Parser stage: command decode, bus handshake, reply hand-off to TX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= P_IDLE;
      o_bus_req   <= 1'b0;
      o_bus_rw    <= 1'b1;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      reply_byte  <= '0;
      tx_load     <= 1'b0;
      to_cnt      <= '0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      tx_load <= 1'b0;
      if (frame_err_pulse) o_frame_err <= 1'b1;
      if (rx_valid || !in_cmd) to_cnt <= '0;
      else                     to_cnt <= to_cnt + 1'b1;

      case (state)
        P_IDLE: begin
          if (rx_valid) begin
            if (rx_byte == CMD_READ) begin
              o_bus_rw <= 1'b1;
              state    <= P_ADDR_HI;
            end else if (rx_byte == CMD_WRITE) begin
              o_bus_rw <= 1'b0;
              state    <= P_ADDR_HI;
            end
          end
        end
        P_ADDR_HI: begin
          if (rx_valid) begin
            o_bus_addr[15:8] <= rx_byte;
            state            <= P_ADDR_LO;
          end else if (&to_cnt) begin
            state <= P_IDLE;
          end
        end
        P_ADDR_LO: begin
          if (rx_valid) begin
            o_bus_addr[7:0] <= rx_byte;
            state           <= o_bus_rw ? P_BUS : P_DATA;
          end else if (&to_cnt) begin
            state <= P_IDLE;
          end
        end
        P_DATA: begin
          if (rx_valid) begin
            o_bus_wdata <= rx_byte;
            state       <= P_BUS;
          end else if (&to_cnt) begin
            state <= P_IDLE;
          end
        end
        P_BUS: begin
          if (rx_valid) o_overrun <= 1'b1;
          // An ack is only honoured once our request is actually visible on the bus.
          if (o_bus_req && i_bus_ack) begin
            o_bus_req <= 1'b0;
            if (o_bus_rw) begin
              reply_byte <= i_bus_rdata;
              tx_load    <= 1'b1;
              state      <= P_REPLY;
            end else begin
`ifdef UART_BRIDGE_WRITE_ACK_EN
              reply_byte <= RSP_WACK;
              tx_load    <= 1'b1;
              state      <= P_REPLY;
`else
              state      <= P_IDLE;
`endif
            end
          end else begin
            o_bus_req <= 1'b1;
          end
        end
        P_REPLY: begin
          if (rx_valid) o_overrun <= 1'b1;
          if (!tx_load && !tx_busy) state <= P_IDLE;
        end
        default: state <= P_IDLE;
      endcase
    end
  end

  // TX stage: the line register trails the shifter by one clock, giving 2 clk from ack to start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_busy   <= 1'b0;
      tx_shift  <= '1;
      tx_cnt    <= '0;
      tx_bits   <= '0;
      o_UART_RX <= 1'b1;
    end else begin
      o_UART_RX <= tx_busy ? tx_shift[0] : 1'b1;
      if (tx_load) begin
        tx_shift <= {1'b1, reply_byte, 1'b0};
        tx_busy  <= 1'b1;
        tx_cnt   <= '0;
        tx_bits  <= '0;
      end else if (tx_busy) begin
        if (tx_cnt == FULL_BIT) begin
          tx_cnt   <= '0;
          tx_shift <= {1'b1, tx_shift[TX_FRAME_W-1:1]};
          tx_bits  <= tx_bits + 1'b1;
          if (tx_bits == 4'(TX_FRAME_W - 1)) tx_busy <= 1'b0;
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/uart_host_bridge.md
Name: uart_host_bridge

Overview:
- Host-side debug/loader bridge on the FT2232 serial link, at the opposite end of the 6809 UART data path.
- Receives command bytes from the host on i_UART_TX and decodes them into 6809-space memory read/write cycles on a simple req/ack bus.
- Returns read data to the host on o_UART_RX.
- Used for program load and memory inspection while the 6809 is held or idle.

Parameters:
- CLKS_PER_BIT, 9236, system clocks per serial bit (88.67 MHz / 9600 bps).
- TIMEOUT_BITS, 20, width of the inter-byte timeout counter; a partial command is dropped when it saturates.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_UART_TX  in  1  serial data from host (idle high)
- o_UART_RX  out  1  serial data to host (idle high)
- o_bus_addr  out  16  target address
- o_bus_wdata  out  8  write data
- i_bus_rdata  in  8  read data, valid in the cycle i_bus_ack is high
- o_bus_req  out  1  bus request, held until ack
- o_bus_rw  out  1  1 = read, 0 = write
- i_bus_ack  in  1  single-cycle acknowledge from bus arbiter
- o_busy  out  1  high whenever the parser is not in IDLE
- o_frame_err  out  1  sticky, set on a bad stop bit or a false start
- o_overrun  out  1  sticky, set when a byte is dropped because the parser cannot accept it

Behaviour:
- Reset values (async, active-high):
  - o_UART_RX=1; o_bus_req=0; o_bus_rw=1; o_bus_addr=0; o_bus_wdata=0; o_busy=0; o_frame_err=0; o_overrun=0.
  - All FSMs return to IDLE and all counters clear.
  - Reset mid-frame aborts with no bus cycle and no reply; the TX line returns high immediately.
- RX path:
  - i_UART_TX passes through a 2-FF synchronizer.
  - A falling edge in RX_IDLE starts a bit counter; the line is resampled at CLKS_PER_BIT/2.
  - If the line is high at that sample: false start, set o_frame_err, return to RX_IDLE.
  - Otherwise sample 8 data bits LSB-first at CLKS_PER_BIT intervals, then sample the stop bit.
  - Stop bit 0: set o_frame_err, discard the byte.
  - Stop bit 1: pulse rx_valid for 1 clk with rx_byte.
  - The RX path never stalls.
- Parser FSM: IDLE -> ADDR_HI -> ADDR_LO -> [DATA] -> BUS -> [REPLY] -> IDLE.
  - IDLE: 0x52 'R' sets rw=1; 0x57 'W' sets rw=0; any other byte is ignored silently.
  - ADDR_HI / ADDR_LO: latch o_bus_addr[15:8] / [7:0]. After ADDR_LO, a read goes to BUS and a write goes to DATA.
  - DATA: latch o_bus_wdata, go to BUS.
  - BUS:
    - o_bus_req is asserted the cycle after entry and held until i_bus_ack.
    - On ack: capture i_bus_rdata on a read; drop req the next cycle.
    - Read goes to REPLY; write goes to IDLE.
  - REPLY: load the TX shifter, go to IDLE once TX completes.
  - rx_valid arriving in BUS or REPLY: byte dropped, o_overrun set.
  - Timeout: a counter clears on each rx_valid and increments in ADDR_HI/ADDR_LO/DATA. At all-ones it returns to IDLE with no bus cycle.
  - Ack in the same cycle as req assertion is legal.
  - Ack while req is low is ignored.
- TX path:
  - 10-bit frame {1, data, 0}, sent LSB-first with CLKS_PER_BIT clocks per bit.
  - Line held at 1 when idle.
  - Latency from ack to the start-bit falling edge: 2 clk.

Optional Feature:
- UART_BRIDGE_WRITE_ACK_EN defined: after a completed write, BUS goes to REPLY and transmits 0x4B 'K'.
- Undefined: writes produce no serial output, and BUS goes straight to IDLE.

Decomposition:
- Package uart_bridge_pkg holds:
  - opcodes CMD_READ=8'h52, CMD_WRITE=8'h57, RSP_WACK=8'h4B
  - parser state enum
  - TX frame width constant 10
- One natural sub-module, uart_byte_rx: synchronizer, bit timing and frame check, with outputs rx_byte, rx_valid, frame_err_pulse.
- TX and the parser stay in the top level.

Test Plan:
- Host sends 0x57,0x12,0x34,0xA5; ack after 3 clk -> one req with rw=0, addr=0x1234, wdata=0xA5. No serial reply (macro off); 'K' (0x4B) with the macro on.
- Host sends 0x52,0xC0,0x00; rdata=0x3C with ack -> req with rw=1, addr=0xC000; o_UART_RX emits 0,0,0,1,1,1,1,0,0,1 at CLKS_PER_BIT spacing.
- Stop bit forced 0 on the 0x34 byte -> o_frame_err=1, no bus cycle; the following 0x52,0x00,0x10 read proceeds normally.
- 0x52,0x80 then silence (TIMEOUT_BITS=8 in the bench) -> parser back in IDLE, o_busy=0, no req.
- A byte sent while ack is withheld in BUS -> o_overrun=1; the read completes and replies correctly.
- Reset asserted in the middle of the reply's data bit 4 -> o_UART_RX=1 immediately, o_busy=0, all flags 0.
